instruction_memory_sync: RTL and testbench

INSTRUCTION_MEMORY_SYNC -- requirements
Module: instruction_memory_sync

---
 rtl/instruction_memory_sync.sv | 227 ++++++++++++++++++++++
 tb/tb_instruction_memory_sync.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_sync.sv
// instruction_memory_sync: word-organised instruction store with a fixed
// number of read wait states, a valid/fault response and a load port.
//
// Parameters:
//   ADDR_W      byte-address width
//   DATA_W      instruction word width (multiple of 8)
//   DEPTH       number of words stored
//   WAIT_CYCLES extra read wait states (0..15)
//
// Ports:
//   CLK      clock, all state updates on its rising edge
//   Reset    synchronous active-high reset
//   req      fetch request, taken on an edge where ready=1
//   Address  fetch byte address
//   ready    high while a request can be accepted
//   valid    one-cycle pulse, Data/fault are the fetch result
//   Data     fetched word, held between pulses, 0 on fault
//   fault    qualifies valid: misaligned or out-of-range fetch
//   wr_en    program-load write strobe, honoured in any state
//   wr_addr  load byte address
//   wr_data  load word
//
// Build option IMEM_PREFETCH_EN: after every non-faulting fetch of A the
// word at A+DATA_W/8 is read into a one-entry buffer with the same wait
// timing; a request hitting that buffer completes one cycle after accept.

module instruction_memory_sync #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] Address,
  output logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] Data,
  output logic              fault,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BYTES);
  localparam logic [3:0]        WAIT_N   = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Aligned to a word and inside the array.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ((a & LOW_MASK) == '0) && ((a >> OFF) < DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> OFF);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_d;
  logic [3:0]        cnt;
  logic [3:0]        cnt_d;
  logic [ADDR_W-1:0] addr_q;

  logic              accept;
  logic              capture;
  logic              hit;
  logic              pf_busy;
  logic              rd_ok;
  logic [IDX_W-1:0]  rd_idx;

  assign rd_ok  = addr_ok(addr_q);
  assign rd_idx = widx(addr_q);

  assign ready  = (state == IDLE) && !pf_busy;
  assign accept = req && ready;

  // Program load: any edge, any state, including reset edges.
  // Bad addresses are dropped rather than aliased onto a real word.
  always_ff @(posedge CLK) begin
    if (wr_en && addr_ok(wr_addr)) begin
      mem[widx(wr_addr)] <= wr_data;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = hit ? 4'd0 : WAIT_N;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_d = RESP;
          capture = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (Reset) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      capture = 1'b0;
    end
  end

`ifdef IMEM_PREFETCH_EN

  logic              pf_ok;
  logic [IDX_W-1:0]  pf_idx;
  logic [3:0]        pf_cnt;
  logic [ADDR_W-1:0] pf_addr;
  logic              buf_v;
  logic [ADDR_W-1:0] buf_tag;
  logic [DATA_W-1:0] buf_data;
  logic              hit_q;
  logic              last_ok;

  assign pf_ok  = addr_ok(pf_addr);
  assign pf_idx = widx(pf_addr);

  // A write in the same edge could make the buffered word stale.
  assign hit = buf_v && (Address == buf_tag) && !wr_en;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pf_busy <= 1'b0;
      pf_cnt  <= 4'd0;
      pf_addr <= '0;
      buf_v   <= 1'b0;
      hit_q   <= 1'b0;
      last_ok <= 1'b0;
    end else begin
      if (accept) begin
        hit_q <= hit;
      end else if (capture) begin
        hit_q <= 1'b0;
      end
      if (capture) begin
        last_ok <= rd_ok;
      end
      if (pf_busy) begin
        if (wr_en) begin
          pf_busy <= 1'b0;
        end else if (pf_cnt == 4'd0) begin
          pf_busy  <= 1'b0;
          buf_v    <= pf_ok;
          buf_tag  <= pf_addr;
          buf_data <= pf_ok ? mem[pf_idx] : '0;
        end else begin
          pf_cnt <= pf_cnt - 4'd1;
        end
      end else if ((state == RESP) && last_ok && !wr_en) begin
        pf_busy <= 1'b1;
        pf_cnt  <= WAIT_N;
        pf_addr <= addr_q + STEP;
      end
      if (wr_en || (capture && !rd_ok)) begin
        buf_v <= 1'b0;
      end
    end
  end

`else

  assign hit     = 1'b0;
  assign pf_busy = 1'b0;

`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      valid  <= 1'b0;
      fault  <= 1'b0;
      Data   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      valid <= capture;
      if (accept) begin
        addr_q <= Address;
      end
      // The array read sits on the WAIT->RESP edge; a same-edge load
      // of this word lands after it, so the old word is returned.
      if (capture) begin
        fault <= !rd_ok;
`ifdef IMEM_PREFETCH_EN
        Data <= !rd_ok ? '0 : (hit_q ? buf_data : mem[rd_idx]);
`else
        Data <= rd_ok ? mem[rd_idx] : '0;
`endif
      end else if (state == RESP) begin
        fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Directed bench for instruction_memory_sync: one instance with two wait
// states, one with none; expected responses are queued and popped on valid.

module tb_instruction_memory_sync;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;

  logic        req_a, rdy_a, vld_a, flt_a;
  logic [63:0] addr_a;
  logic [31:0] data_a;
  logic        req_b, rdy_b, vld_b, flt_b;
  logic [63:0] addr_b;
  logic [31:0] data_b;

  typedef struct {
    logic [31:0] data;
    logic        flt;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk;
  int   n_fail;
  int   cyc;

`ifdef IMEM_PREFETCH_EN
  localparam int SEQ_LAT = 1;
`else
  localparam int SEQ_LAT = 3;
`endif

  instruction_memory_sync #(
    .ADDR_W(64), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2)
  ) dut_a (
    .CLK(clk), .Reset(rst), .req(req_a), .Address(addr_a),
    .ready(rdy_a), .valid(vld_a), .Data(data_a), .fault(flt_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  instruction_memory_sync #(
    .ADDR_W(64), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)
  ) dut_b (
    .CLK(clk), .Reset(rst), .req(req_b), .Address(addr_b),
    .ready(rdy_b), .valid(vld_b), .Data(data_b), .fault(flt_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [63:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_ready(input bit b);
    int n;
    n = 0;
    while (!(b ? rdy_b : rdy_a) && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(b ? rdy_b : rdy_a), 64'd1);
  endtask

  task automatic fetch(input bit b, input logic [63:0] a,
                       input logic [31:0] d, input bit f,
                       input int lat, output int acc);
    exp_t e;
    int   n;
    logic v;
    logic [31:0] o;
    wait_ready(b);
    if (b) begin
      req_b = 1'b1; addr_b = a;
    end else begin
      req_a = 1'b1; addr_a = a;
    end
    tick();
    req_a = 1'b0;
    req_b = 1'b0;
    acc = cyc;
    e.data = d; e.flt = f; e.lat = lat;
    sbq.push_back(e);
    n = 0;
    while (!(b ? vld_b : vld_a) && n < 50) begin
      tick();
      n++;
    end
    e = sbq.pop_front();
    v = b ? vld_b : vld_a;
    o = b ? data_b : data_a;
    chk("valid", 64'(v), 64'd1);
    chk("data", 64'(o), 64'(e.data));
    chk("fault", 64'(b ? flt_b : flt_a), 64'(e.flt));
    chk("latency", 64'(cyc - acc), 64'(e.lat));
    tick();
    chk("valid_pulse", 64'(b ? vld_b : vld_a), 64'd0);
    chk("data_hold", 64'(b ? data_b : data_a), 64'(e.data));
  endtask

  initial begin
    int a0, a1, a2, n;
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_a = 1'b0; addr_a = '0; req_b = 1'b0; addr_b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 64'(rdy_a), 64'd1);
    chk("rst_valid", 64'(vld_a), 64'd0);
    chk("rst_fault", 64'(flt_a), 64'd0);
    chk("rst_data", 64'(data_a), 64'd0);

    write(64'h0, 32'hF84003E9);
    write(64'h4, 32'hF84083EA);
    write(64'h8, 32'h00000013);
    write(64'h20, 32'h0);
    write(64'h100, 32'hDEADBEEF);
    write(64'h2, 32'hCAFEF00D);

    fetch(0, 64'h0, 32'hF84003E9, 0, 3, a0);
    fetch(0, 64'h6, 32'h0, 1, 3, a1);
`ifndef IMEM_PREFETCH_EN
    chk("spacing_w2", 64'(a1 - a0), 64'd5);
`endif
    fetch(0, 64'h100, 32'h0, 1, 3, a0);
    fetch(0, 64'h4, 32'hF84083EA, 0, 3, a0);

    wait_ready(0);
    req_a = 1'b1; addr_a = 64'h8;
    tick();
    req_a = 1'b0;
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 64'h8; wr_data = 32'h12345678;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    chk("abort_ready", 64'(rdy_a), 64'd1);
    chk("abort_valid", 64'(vld_a), 64'd0);
    chk("abort_data", 64'(data_a), 64'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (vld_a) n++;
      tick();
    end
    chk("abort_no_pulse", 64'(n), 64'd0);

    fetch(0, 64'h4, 32'hF84083EA, 0, 3, a0);
    fetch(0, 64'h8, 32'h12345678, 0, SEQ_LAT, a0);

    wait_ready(0);
    req_a = 1'b1; addr_a = 64'h20;
    tick();
    req_a = 1'b0;
    tick();
    tick();
    wr_en = 1'b1; wr_addr = 64'h20; wr_data = 32'h8B0901AD;
    tick();
    wr_en = 1'b0;
    chk("coll_valid", 64'(vld_a), 64'd1);
    chk("coll_data", 64'(data_a), 64'd0);
    chk("coll_fault", 64'(flt_a), 64'd0);
    tick();
    fetch(0, 64'h20, 32'h8B0901AD, 0, 3, a0);

    fetch(1, 64'h0, 32'hF84003E9, 0, 1, a0);
    fetch(1, 64'h4, 32'hF84083EA, 0, 1, a1);
    fetch(1, 64'h8, 32'h12345678, 0, 1, a2);
`ifndef IMEM_PREFETCH_EN
    chk("spacing_w0_a", 64'(a1 - a0), 64'd3);
    chk("spacing_w0_b", 64'(a2 - a1), 64'd3);
`endif

`ifdef IMEM_PREFETCH_EN
    fetch(0, 64'h0, 32'hF84003E9, 0, 3, a0);
    fetch(0, 64'h4, 32'hF84083EA, 0, 1, a0);
    wait_ready(0);
    write(64'h24, 32'h00000013);
    fetch(0, 64'h8, 32'h12345678, 0, 3, a0);
`endif

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
